// File: rtl/latch_bank_ctrl_pkg.sv
// Shared types and constants for the latch bank write controller.
package latch_bank_ctrl_pkg;

  // Write sequencing states.
  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StPulse,
    StHold,
    StCheck
  } lbc_state_e;

  // Width of the saturating error counter.
  localparam int unsigned ErrCntW = 8;

endpackage

// File: rtl/latch_bank_ctrl_if.sv
// Two-requester write handshake bundle between requesters and the controller.
interface latch_bank_ctrl_if #(
  parameter int unsigned WIDTH = 8
);

  logic             req0_valid;
  logic [WIDTH-1:0] req0_data;
  logic             req0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_data;
  logic             req1_ready;

  // Requester side.
  modport master (
    output req0_valid, req0_data, req1_valid, req1_data,
    input  req0_ready, req1_ready
  );

  // Controller side.
  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data,
    output req0_ready, req1_ready
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: on a tie the requester not served last wins.
module rr_arb2 (
  input  logic valid0_i,
  input  logic valid1_i,
  input  logic last_grant_i,
  output logic grant_o
);

  // grant_o is only meaningful when at least one valid is high.
  always_comb begin
    grant_o = 1'b0;
    if (valid0_i && valid1_i) begin
      grant_o = ~last_grant_i;
    end else if (valid1_i) begin
      grant_o = 1'b1;
    end
  end

endmodule

// File: rtl/latch_bank_ctrl.sv
// Write controller for an external bank of gated SR latches: arbitrates two
// requesters, sequences set/reset drive around an enable pulse, and verifies
// the bank read-back.
module latch_bank_ctrl
  import latch_bank_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned EN_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  latch_bank_ctrl_if.slave   req_if,
  output logic [WIDTH-1:0]   S,
  output logic [WIDTH-1:0]   R,
  output logic               en,
  input  logic [WIDTH-1:0]   Q,
  output logic               busy,
  output logic               done,
  output logic               grant_id,
  output logic               err,
  output logic [ErrCntW-1:0] err_cnt
);

  lbc_state_e         state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [WIDTH-1:0]   wr_data_q, wr_data_d;
  logic               grant_id_q, grant_id_d;
  logic               last_grant_q, last_grant_d;
  logic [ErrCntW-1:0] err_cnt_q, err_cnt_d;

  logic arb_grant;
  logic idle;
  logic accept;
  logic mismatch;
  logic drive;

  rr_arb2 u_arb (
    .valid0_i     (req_if.req0_valid),
    .valid1_i     (req_if.req1_valid),
    .last_grant_i (last_grant_q),
    .grant_o      (arb_grant)
  );

  // Handshake: ready only in IDLE, only to the granted requester, never in reset.
  always_comb begin
    idle              = (state_q == StIdle) && !rst;
    req_if.req0_ready = idle && req_if.req0_valid && !arb_grant;
    req_if.req1_ready = idle && req_if.req1_valid && arb_grant;
    accept            = req_if.req0_ready || req_if.req1_ready;
    mismatch          = (Q != wr_data_q);
  end

  // Next-state logic for sequencing, capture, arbitration history and error count.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wr_data_d    = wr_data_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    err_cnt_d    = err_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          wr_data_d    = arb_grant ? req_if.req1_data : req_if.req0_data;
          grant_id_d   = arb_grant;
          last_grant_d = arb_grant;
          state_d      = StSetup;
        end
      end
      StSetup: begin
        // Counter reaches zero on the last enable cycle.
        cnt_d   = 4'(EN_CYCLES - 1);
        state_d = StPulse;
      end
      StPulse: begin
        if (cnt_q == 4'd0) begin
          state_d = StHold;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StHold: begin
        state_d = StCheck;
      end
      StCheck: begin
        if (mismatch && (err_cnt_q != '1)) begin
          err_cnt_d = err_cnt_q + ErrCntW'(1);
        end
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers; reset also discards any in-flight write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= 4'd0;
      wr_data_q    <= '0;
      grant_id_q   <= 1'b0;
      last_grant_q <= 1'b1;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wr_data_q    <= wr_data_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  // Bank drive: S/R are complementary from SETUP through HOLD so en only
  // toggles while S/R are already settled; both are zero elsewhere.
  always_comb begin
    drive    = (state_q == StSetup) || (state_q == StPulse) || (state_q == StHold);
    S        = drive ? wr_data_q : '0;
    R        = drive ? ~wr_data_q : '0;
    en       = (state_q == StPulse);
    busy     = (state_q != StIdle);
    done     = (state_q == StCheck);
    err      = done && mismatch;
    grant_id = grant_id_q;
    err_cnt  = err_cnt_q;
  end

endmodule

// File: tb/tb_latch_bank_ctrl.sv
// Directed bench for latch_bank_ctrl with a behavioural gated SR latch bank.
module tb_latch_bank_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  // Default build (EN_CYCLES=2).
  latch_bank_ctrl_if #(.WIDTH(8)) rif ();
  logic [7:0] s, r, q, stuck;
  logic [7:0] q_lat = 8'h00;
  logic       en, busy, done, gid, err;
  logic [7:0] ecnt;

  latch_bank_ctrl #(.WIDTH(8), .EN_CYCLES(2)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .req_if   (rif),
    .S        (s),
    .R        (r),
    .en       (en),
    .Q        (q),
    .busy     (busy),
    .done     (done),
    .grant_id (gid),
    .err      (err),
    .err_cnt  (ecnt)
  );

  // Gated SR latch cells, one per bit; stuck forces selected outputs low.
  always @(en, s, r) if (en) q_lat = (q_lat & ~r) | s;
  assign q = q_lat & ~stuck;

  // Long-enable build (EN_CYCLES=15).
  latch_bank_ctrl_if #(.WIDTH(8)) rif15 ();
  logic [7:0] s15, r15, q15;
  logic [7:0] q15_lat = 8'h00;
  logic       en15, busy15, done15, gid15, err15;
  logic [7:0] ecnt15;

  latch_bank_ctrl #(.WIDTH(8), .EN_CYCLES(15)) u_dut15 (
    .clk      (clk),
    .rst      (rst),
    .req_if   (rif15),
    .S        (s15),
    .R        (r15),
    .en       (en15),
    .Q        (q15),
    .busy     (busy15),
    .done     (done15),
    .grant_id (gid15),
    .err      (err15),
    .err_cnt  (ecnt15)
  );

  always @(en15, s15, r15) if (en15) q15_lat = (q15_lat & ~r15) | s15;
  assign q15 = q15_lat;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Step until done is seen; an expired budget counts as a failed comparison.
  task automatic wait_done();
    for (int i = 0; i < 60; i++) begin
      tick();
      if (done) return;
    end
    check("done_timeout", {31'd0, done}, 32'd1);
  endtask

  // Protocol invariants, sampled mid-cycle while the random phase runs.
  logic       mon_on = 1'b0;
  logic       en_p = 1'b0;
  logic [7:0] s_p = 8'h00, r_p = 8'h00;
  always @(negedge clk) begin
    if (mon_on) begin
      check("inv_s_and_r", {31'd0, |(s & r)}, 32'd0);
      check("inv_ready_busy",
            {31'd0, (rif.req0_ready | rif.req1_ready) & busy}, 32'd0);
      check("inv_en_stable",
            {31'd0, (en != en_p) && ((s != s_p) || (r != r_p))}, 32'd0);
    end
    en_p = en;
    s_p  = s;
    r_p  = r;
  end

  logic [1:0] exp_g;
  logic       model_last;
  logic [7:0] exp_wr;
  int         acc;
  int         cyc;
  int         en_cnt;
  int         done_at;
  logic       v0, v1, g;

  initial begin
    rst = 1'b1;
    stuck = 8'h00;
    rif.req0_valid = 1'b1;
    rif.req0_data  = 8'hA5;
    rif.req1_valid = 1'b0;
    rif.req1_data  = 8'h00;
    rif15.req0_valid = 1'b0;
    rif15.req0_data  = 8'h00;
    rif15.req1_valid = 1'b0;
    rif15.req1_data  = 8'h00;

    // Reset state, with a request already pending.
    tick();
    tick();
    check("rst_s", {24'd0, s}, 32'h0);
    check("rst_r", {24'd0, r}, 32'h0);
    check("rst_en_busy_done_err", {28'd0, en, busy, done, err}, 32'h0);
    check("rst_ready", {30'd0, rif.req0_ready, rif.req1_ready}, 32'h0);
    check("rst_gid", {31'd0, gid}, 32'h0);
    check("rst_errcnt", {24'd0, ecnt}, 32'h0);

    // Single write of A5 by requester 0, accepted on the first edge after reset.
    rst = 1'b0;
    #1;
    check("single_ready0", {31'd0, rif.req0_ready}, 32'd1);
    tick();
    rif.req0_valid = 1'b0;
    check("setup_s", {24'd0, s}, 32'hA5);
    check("setup_r", {24'd0, r}, 32'h5A);
    check("setup_en", {31'd0, en}, 32'd0);
    check("setup_busy_ready", {30'd0, busy, rif.req0_ready}, 32'h2);
    tick();
    check("pulse1_en", {31'd0, en}, 32'd1);
    tick();
    check("pulse2_en", {31'd0, en}, 32'd1);
    tick();
    check("hold_en", {31'd0, en}, 32'd0);
    check("hold_sr", {16'd0, s, r}, 32'hA55A);
    check("hold_done", {31'd0, done}, 32'd0);
    tick();
    check("check_done_err", {30'd0, done, err}, 32'h2);
    check("check_q", {24'd0, q}, 32'hA5);
    check("check_sr", {16'd0, s, r}, 32'h0);
    check("check_gid", {31'd0, gid}, 32'd0);
    tick();
    check("after_done_busy", {30'd0, done, busy}, 32'h0);

    // Contention: both requesters valid from reset alternate 0,1,0,1.
    do_reset();
    rif.req0_valid = 1'b1;
    rif.req0_data  = 8'h0F;
    rif.req1_valid = 1'b1;
    rif.req1_data  = 8'hF0;
    for (int i = 0; i < 4; i++) begin
      exp_g = 2'(i % 2);
      wait_done();
      check("cont_gid", {31'd0, gid}, {31'd0, exp_g[0]});
      check("cont_q", {24'd0, q}, exp_g[0] ? 32'hF0 : 32'h0F);
      check("cont_err", {31'd0, err}, 32'd0);
    end
    rif.req0_valid = 1'b0;
    rif.req1_valid = 1'b0;
    tick();
    tick();

    // Mismatch: bit 3 stuck low, writes of FF flag err and count to saturation.
    stuck = 8'h08;
    rif.req0_data  = 8'hFF;
    rif.req0_valid = 1'b1;
    wait_done();
    check("mm_err", {30'd0, done, err}, 32'h3);
    check("mm_q", {24'd0, q}, 32'hF7);
    tick();
    check("mm_errcnt1", {24'd0, ecnt}, 32'd1);
    for (int i = 0; i < 254; i++) wait_done();
    tick();
    check("mm_errcnt255", {24'd0, ecnt}, 32'd255);
    wait_done();
    tick();
    check("mm_errcnt_sat", {24'd0, ecnt}, 32'd255);
    rif.req0_valid = 1'b0;
    stuck = 8'h00;
    tick();
    tick();

    // Reset in the 2nd PULSE cycle of a requester-1 write.
    do_reset();
    check("rst2_errcnt", {24'd0, ecnt}, 32'd0);
    rif.req0_valid = 1'b1;
    rif.req0_data  = 8'h3C;
    wait_done();
    check("rw_first_gid", {31'd0, gid}, 32'd0);
    rif.req0_data  = 8'h11;
    rif.req1_valid = 1'b1;
    rif.req1_data  = 8'h22;
    tick();
    check("rw_ready1", {30'd0, rif.req0_ready, rif.req1_ready}, 32'h1);
    tick();
    tick();
    tick();
    check("rw_pulse2_en", {31'd0, en}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("rw_async_en", {31'd0, en}, 32'd0);
    check("rw_async_sr", {16'd0, s, r}, 32'h0);
    check("rw_async_busy_done", {30'd0, busy, done}, 32'h0);
    @(posedge clk);
    #1;
    check("rw_no_done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    #1;
    check("rw_regrant", {30'd0, rif.req0_ready, rif.req1_ready}, 32'h2);
    wait_done();
    check("rw_next_gid", {31'd0, gid}, 32'd0);
    check("rw_next_q", {24'd0, q}, 32'h11);
    check("rw_errcnt", {24'd0, ecnt}, 32'd0);
    rif.req0_valid = 1'b0;
    rif.req1_valid = 1'b0;
    tick();
    tick();

    // Random traffic with invariant monitor and a round-robin/data model.
    model_last = 1'b0;
    exp_wr = 8'h00;
    acc = 0;
    cyc = 0;
    mon_on = 1'b1;
    while (acc < 1000 && cyc < 30000) begin
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      rif.req0_valid = v0;
      rif.req1_valid = v1;
      rif.req0_data  = 8'($urandom);
      rif.req1_data  = 8'($urandom);
      #1;
      if ((rif.req0_ready && v0) || (rif.req1_ready && v1)) begin
        g = rif.req1_ready;
        check("rnd_rr", {31'd0, g}, (v0 && v1) ? {31'd0, ~model_last} : {31'd0, v1});
        model_last = g;
        exp_wr = g ? rif.req1_data : rif.req0_data;
        acc++;
      end
      tick();
      cyc++;
      if (done) begin
        check("rnd_q", {24'd0, q}, {24'd0, exp_wr});
        check("rnd_err", {31'd0, err}, 32'd0);
      end
    end
    check("rnd_accepts", acc, 32'd1000);
    rif.req0_valid = 1'b0;
    rif.req1_valid = 1'b0;
    wait_done();
    tick();
    mon_on = 1'b0;

    // EN_CYCLES=15 build: 15 enable cycles, done 18 cycles after acceptance.
    rif15.req0_valid = 1'b1;
    rif15.req0_data  = 8'h55;
    #1;
    check("en15_ready", {31'd0, rif15.req0_ready}, 32'd1);
    tick();
    rif15.req0_valid = 1'b0;
    en_cnt = 0;
    done_at = 0;
    for (int i = 1; i <= 40; i++) begin
      if (en15) en_cnt++;
      if (done15 && done_at == 0) begin
        done_at = i;
        check("en15_q", {24'd0, q15}, 32'h55);
      end
      if (done_at == 0) tick();
    end
    check("en15_en_cycles", en_cnt, 32'd15);
    check("en15_done_lat", done_at, 32'd18);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
